// File: rtl/key_irq_pkg.sv
// Shared types and helpers for the key interrupt controller.
// Key indices, arbiter states and the round-robin pick.
package key_irq_pkg;

  localparam int NKEYS  = 6;
  localparam int KEY_B0 = 0;
  localparam int KEY_B1 = 1;
  localparam int KEY_B2 = 2;
  localparam int KEY_B3 = 3;
  localparam int KEY_A  = 4;
  localparam int KEY_BB = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_REL
  } state_e;

  // First set bit searching upward from last+1, wrapping at NKEYS.
  function automatic logic [2:0] rr_pick(
    input logic [NKEYS-1:0] req,
    input logic [2:0]       last
  );
    logic [2:0] sel;
    logic       hit;
    int         j;
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= NKEYS; k++) begin
      j = (int'(last) + k) % NKEYS;
      if (!hit && req[j]) begin
        sel = 3'(j);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: synchronizer, tick-based debounce and auto-repeat.
// level is the accepted pressed state; evt pulses on press/repeat.
module key_debounce
  import key_irq_pkg::*;
#(
  parameter int DEB_TICKS = 4,
  parameter int REP_DELAY = 24,
  parameter int REP_RATE  = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_n,
  output logic level,
  output logic evt
);

  localparam logic [15:0] DEB_LAST  = 16'(DEB_TICKS - 1);
  localparam logic [15:0] DLY_LAST  = 16'(REP_DELAY - 1);
  localparam logic [15:0] RATE_LAST = 16'(REP_RATE - 1);

  logic        s1;
  logic        s2;
  logic        rep;
  logic [15:0] dcnt;
  logic [15:0] rcnt;

  // Two-flop synchronizer, inverted to active-high pressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
    end
  end

  // Stability count, level update, press and repeat events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      evt   <= 1'b0;
      rep   <= 1'b0;
      dcnt  <= '0;
      rcnt  <= '0;
    end else begin
      evt <= 1'b0;
      if (s2 == level) begin
        dcnt <= '0;
      end else if (tick) begin
        if (dcnt == DEB_LAST) begin
          level <= s2;
          dcnt  <= '0;
          evt   <= s2;
        end else begin
          dcnt <= dcnt + 16'd1;
        end
      end
      if (!level) begin
        rcnt <= '0;
        rep  <= 1'b0;
      end else if (tick) begin
        if (rcnt == (rep ? RATE_LAST : DLY_LAST)) begin
          evt  <= 1'b1;
          rcnt <= '0;
          rep  <= 1'b1;
        end else begin
          rcnt <= rcnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/key_irq_ctrl.sv
// Button interrupt controller: prescaler, pending bits, EI/DI flag,
// round-robin arbiter and the irq/vector/ack handshake FSM.
module key_irq_ctrl
  import key_irq_pkg::*;
#(
  parameter int TICK_DIV  = 65536,
  parameter int DEB_TICKS = 4,
  parameter int REP_DELAY = 24,
  parameter int REP_RATE  = 6,
  parameter int VEC_BASE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys_n,
  input  logic             ei,
  input  logic             di,
  input  logic             cpu_ready,
  output logic             irq,
  output logic [7:0]       vector,
  input  logic             ack,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] pending,
  output logic             ie
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [NKEYS-1:0] evt;
  logic [NKEYS-1:0] clr;
  state_e           state_q;
  state_e           state_d;
  logic [2:0]       grant_q;
  logic [2:0]       grant_d;
  logic [2:0]       last_q;
  logic [2:0]       last_d;
  logic [2:0]       pick;
  logic             irq_d;
  logic [7:0]       vec_d;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  // Free-running prescaler wrapping every TICK_DIV cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcnt <= '0;
    else      pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(
      .DEB_TICKS (DEB_TICKS),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .key_n (keys_n[g]),
      .level (key_level[g]),
      .evt   (evt[g])
    );
  end

  // Pending bits: new events win over the grant clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr) | evt;
  end

  // Interrupt enable; DI dominates a simultaneous EI.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    ie <= 1'b1;
    else if (di) ie <= 1'b0;
    else if (ei) ie <= 1'b1;
  end

  // Arbiter state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 3'd5;
      irq     <= 1'b0;
      vector  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      irq     <= irq_d;
      vector  <= vec_d;
    end
  end

  // Next-state: grant at a boundary, retire on ack, wait for release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    irq_d   = irq;
    vec_d   = vector;
    clr     = '0;
    pick    = rr_pick(pending, last_q);
    unique case (state_q)
      IDLE: begin
        if (ie && (|pending) && cpu_ready) begin
          grant_d = pick;
          vec_d   = 8'(VEC_BASE + 2 * int'(pick));
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          clr     = NKEYS'(1) << grant_q;
          last_d  = grant_q;
          irq_d   = 1'b0;
          state_d = WAIT_REL;
        end else if (di) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT_REL: begin
        if (!ack) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Directed bench for key_irq_ctrl with a fast tick.
// Drives and samples on the falling clock edge.
module tb_key_irq_ctrl;

  localparam int VB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] keys_n = 6'h3F;
  logic       ei = 1'b0;
  logic       di = 1'b0;
  logic       cpu_ready = 1'b0;
  logic       ack = 1'b0;
  logic       irq;
  logic [7:0] vector;
  logic [5:0] key_level;
  logic [5:0] pending;
  logic       ie;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]      press;
    int              n;
    logic [2:0][7:0] vecs;
  } row_t;

  row_t tbl[5];

  key_irq_ctrl #(
    .TICK_DIV  (4),
    .DEB_TICKS (2),
    .REP_DELAY (6),
    .REP_RATE  (3),
    .VEC_BASE  (VB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_n    (keys_n),
    .ei        (ei),
    .di        (di),
    .cpu_ready (cpu_ready),
    .irq       (irq),
    .vector    (vector),
    .ack       (ack),
    .key_level (key_level),
    .pending   (pending),
    .ie        (ie)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_level(input logic [5:0] m, input string nm);
    for (int i = 0; i < 60 && key_level !== m; i++) step();
    chk(nm, 32'(key_level), 32'(m));
  endtask

  task automatic wait_pend(input logic [5:0] m, input string nm);
    for (int i = 0; i < 60 && (pending & m) !== m; i++) step();
    chk(nm, 32'(pending & m), 32'(m));
  endtask

  task automatic wait_irq(input string nm);
    for (int i = 0; i < 60 && irq !== 1'b1; i++) step();
    chk({nm, "_irq"}, 32'(irq), 32'd1);
  endtask

  task automatic do_ack(input logic [7:0] v, input string nm);
    int idx;
    wait_irq(nm);
    chk({nm, "_vec"}, 32'(vector), 32'(v));
    idx = (int'(v) - VB) / 2;
    ack = 1'b1;
    step();
    chk({nm, "_irq_drop"}, 32'(irq), 32'd0);
    chk({nm, "_clr"}, 32'(pending[idx]), 32'd0);
    ack = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int prev;
    int r5;

    tbl[0] = '{press: 6'b101001, n: 3, vecs: {8'd12, 8'd8, 8'd2}};
    tbl[1] = '{press: 6'b001001, n: 2, vecs: {8'd0, 8'd8, 8'd2}};
    tbl[2] = '{press: 6'b010010, n: 2, vecs: {8'd0, 8'd4, 8'd10}};
    tbl[3] = '{press: 6'b100001, n: 2, vecs: {8'd0, 8'd2, 8'd12}};
    tbl[4] = '{press: 6'b000100, n: 1, vecs: {8'd0, 8'd0, 8'd6}};

    step();
    step();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_vector", 32'(vector), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_level", 32'(key_level), 32'd0);
    chk("rst_ie", 32'(ie), 32'd1);
    rst = 1'b1;
    cpu_ready = 1'b1;
    step();

    for (int r = 0; r < 5; r++) begin
      keys_n = ~tbl[r].press;
      wait_level(tbl[r].press, $sformatf("row%0d_level", r));
      step();
      chk($sformatf("row%0d_pend", r), 32'(pending), 32'(tbl[r].press));
      keys_n = 6'h3F;
      wait_level(6'h00, $sformatf("row%0d_rel", r));
      for (int k = 0; k < tbl[r].n; k++)
        do_ack(tbl[r].vecs[k], $sformatf("row%0d_g%0d", r, k));
      chk($sformatf("row%0d_empty", r), 32'(pending), 32'd0);
    end

    keys_n[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && pending[0] !== 1'b1; i++) begin
      step();
      n++;
    end
    chk("b0_latency_ok", 32'(n <= 11), 32'd1);
    chk("b0_level", 32'(key_level[0]), 32'd1);
    do_ack(8'd2, "b0");
    chk("b0_pend_zero", 32'(pending), 32'd0);
    keys_n[0] = 1'b1;
    wait_level(6'h00, "b0_rel");

    cpu_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      keys_n[4] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (key_level[4] || pending[4]) n++;
    end
    chk("bounce_quiet", 32'(n), 32'd0);
    keys_n[4] = 1'b0;
    wait_pend(6'b010000, "bounce_evt");
    cpu_ready = 1'b1;
    do_ack(8'd10, "bounce");
    keys_n[4] = 1'b1;
    wait_level(6'h00, "bounce_rel");
    chk("bounce_single", 32'(pending), 32'd0);

    keys_n[2] = 1'b0;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_irq($sformatf("rep%0d", g));
      chk($sformatf("rep%0d_vec", g), 32'(vector), 32'd6);
      if (g > 0)
        chk($sformatf("rep%0d_gap", g), 32'(cyc - prev),
            (g == 1) ? 32'd24 : 32'd12);
      prev = cyc;
      ack = 1'b1;
      step();
      chk($sformatf("rep%0d_drop", g), 32'(irq), 32'd0);
      ack = 1'b0;
      step();
    end
    wait_irq("rep4");
    chk("rep4_gap", 32'(cyc - prev), 32'd12);
    r5 = cyc;
    for (int i = 0; i < 20 && cyc < r5 + 10; i++) step();
    ack = 1'b1;
    step();
    chk("setwins_irq", 32'(irq), 32'd0);
    chk("setwins_pend", 32'(pending[2]), 32'd1);
    keys_n[2] = 1'b1;
    ack = 1'b0;
    do_ack(8'd6, "rep_last");
    wait_level(6'h00, "rep_rel");
    step();
    step();
    chk("rep_empty", 32'(pending), 32'd0);

    di = 1'b1;
    step();
    di = 1'b0;
    chk("di_ie", 32'(ie), 32'd0);
    keys_n[1] = 1'b0;
    wait_pend(6'b000010, "di_pend");
    keys_n[1] = 1'b1;
    step();
    step();
    step();
    chk("di_no_irq", 32'(irq), 32'd0);
    cpu_ready = 1'b0;
    ei = 1'b1;
    step();
    ei = 1'b0;
    chk("ei_ie", 32'(ie), 32'd1);
    step();
    step();
    step();
    chk("busy_no_irq", 32'(irq), 32'd0);
    cpu_ready = 1'b1;
    wait_irq("ei_go");
    chk("ei_go_vec", 32'(vector), 32'd4);
    di = 1'b1;
    step();
    di = 1'b0;
    chk("req_di_irq", 32'(irq), 32'd0);
    chk("req_di_pend", 32'(pending[1]), 32'd1);
    ei = 1'b1;
    step();
    ei = 1'b0;
    do_ack(8'd4, "ei_again");
    ei = 1'b1;
    di = 1'b1;
    step();
    ei = 1'b0;
    di = 1'b0;
    chk("eidi_ie", 32'(ie), 32'd0);
    ei = 1'b1;
    step();
    ei = 1'b0;
    wait_level(6'h00, "e_rel");

    keys_n[3] = 1'b0;
    wait_irq("mid");
    chk("mid_vec", 32'(vector), 32'd8);
    #2 rst = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_pend", 32'(pending), 32'd0);
    chk("arst_level", 32'(key_level), 32'd0);
    keys_n = 6'h3F;
    step();
    step();
    rst = 1'b1;
    step();
    chk("arst_ie", 32'(ie), 32'd1);
    cpu_ready = 1'b0;
    keys_n = ~6'b010001;
    wait_pend(6'b010001, "post_pend");
    keys_n = 6'h3F;
    cpu_ready = 1'b1;
    do_ack(8'd2, "post_g0");
    do_ack(8'd10, "post_g1");
    wait_level(6'h00, "post_rel");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/key_irq_ctrl.md
# key_irq_ctrl

Interrupt controller and scheduler for the 8-bit matrix CPU's button inputs. Debounces the six raw buttons and generates key-repeat events. Holds one pending bit per key and arbitrates among them round-robin, then drives a registered request/vector/acknowledge handshake at CPU instruction boundaries. Also owns the EI/DI enable flag and exports the debounced key levels that the CPU reads as R5.

## Interface
Parameters:
- TICK_DIV, 65536: clk cycles per debounce/repeat tick (≥2)
- DEB_TICKS, 4: ticks a raw level must stay stable to be accepted
- REP_DELAY, 24: ticks held before the first repeat event
- REP_RATE, 6: ticks between subsequent repeat events
- VEC_BASE, 2: vector of key 0; key i vector = VEC_BASE + 2*i

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- keys_n  in  6  raw buttons, active-low: [3:0]=btn[3:0], [4]=Abtn, [5]=Bbtn
- ei  in  1  one-cycle pulse: set interrupt enable
- di  in  1  one-cycle pulse: clear interrupt enable
- cpu_ready  in  1  CPU is at an instruction boundary (no operand fetch in progress)
- irq  out  1  interrupt request, registered
- vector  out  8  target PC; valid and stable while irq=1
- ack  in  1  CPU has taken the vector (level; 4-phase)
- key_level  out  6  debounced pressed state, active-high
- pending  out  6  pending event bits
- ie  out  1  interrupt enable flag

## Operation
- Prescaler: a free-running counter produces a one-clk `tick` every TICK_DIV cycles. The counter resets to 0.
- Per-key path: a 2-flop synchronizer feeds a stability counter. key_level[i] toggles once the synchronized level has differed from it for DEB_TICKS consecutive ticks. Any bounce back to the old level restarts the count.
- Events, per key:
  - A key_level rising edge raises an event.
  - While the key is held, a repeat counter raises an event after REP_DELAY ticks and then every REP_RATE ticks.
  - Release clears the repeat counter.
- An event sets pending[i]. Events on an already-pending key coalesce; no count is kept.
- ie is set by ei and cleared by di. If ei and di arrive in the same cycle, di wins.
- Arbiter FSM:
  - IDLE: when ie=1, pending≠0 and cpu_ready=1, grant the first pending index searching upward from last_grant+1 (modulo 6). Load vector, set irq, go to REQ.
  - REQ: if ack=1, clear pending[grant], update last_grant, drop irq, go to WAIT_REL. Otherwise, if di=1, drop irq and go to IDLE; pending is kept. When ack and di coincide, ack wins.
  - WAIT_REL: when ack=0, go to IDLE.
- The arbiter does not auto-clear ie. Firmware masks with DI if it needs to.

## Timing
- Reset values:
  - irq=0, vector=0, pending=0, key_level=0
  - ie=1, state=IDLE, last_grant=5 so that key 0 wins the first grant
  - all counters 0
- Press-to-pending latency: 2 clk for the synchronizer, plus DEB_TICKS ticks, plus 1 clk.
- irq and vector update on the same edge, 1 clk after the IDLE condition is met.
- Handshake:
  - ack is sampled each edge.
  - pending clears and irq falls on the edge that samples ack=1.
  - The next grant needs ack=0 to be seen first, so at least 2 clk elapse between grants.
- An event on the key that is being granted, arriving in the same cycle as ack, re-sets pending for that key; set wins over clear.
- Wrap-around: the round-robin search wraps from index 5 to index 0. last_grant is held in 3 bits with values 0–5.
- Reset asserted mid-handshake drops irq immediately (asynchronously) and clears all state.

## Structure
- Package key_irq_pkg holds:
  - state enum {IDLE, REQ, WAIT_REL}
  - NKEYS=6
  - key index constants KEY_B0..KEY_B3, KEY_A, KEY_BB
- Sub-module key_debounce holds the synchronizer, stability counter and repeat counter for one key. It takes tick and outputs level and event. Instantiate it 6 times.
- The top level holds the prescaler, pending register, ie flag, round-robin arbiter and FSM.

## Test plan
All scenarios use TICK_DIV=4, DEB_TICKS=2, REP_DELAY=6, REP_RATE=3, VEC_BASE=2.
- Clean press of btn[0] (keys_n[0]=0 held): key_level[0]=1 and pending[0]=1 within 2+8+1 clk. With cpu_ready=1, irq=1 and vector=2. Ack → irq=0 and pending=0 on the same edge.
- Bounce on keys_n[4] toggling every 3 clk for 40 clk, then stable low: no event during the bounce, then exactly one event. Grant gives vector=10.
- Hold btn[2] for 60 ticks: first event, then repeats at +6 ticks and every 3 ticks after. Pending re-sets after each ack, giving vector=6 each time.
- Keys 0, 3 and 5 pending together, ack every grant: vectors are granted in order 2, 8, 12. Then press key 0 and key 3 again: order 2, 8.
- di, then press btn[1]: pending[1]=1 and irq stays 0. Pulse ei with cpu_ready=0: no irq. Raise cpu_ready → irq with vector=4. Repeat with ei and di in the same cycle: ie=0.
- Assert rst while in REQ with irq=1: irq, pending and key_level read 0 immediately. After release, ie=1 and the first grant goes to the lowest pending index.
